// File: rtl/aes_blk_mem_master_pkg.sv
// Shared types and constants for the AES block <-> byte RAM master.
package aes_blk_mem_master_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned DEF_BLOCK_BYTES = 16;
  localparam int unsigned DEF_DATA_WIDTH  = AES_BLOCK_BITS / DEF_BLOCK_BYTES;
  localparam int unsigned DEF_ADDR_WIDTH  = 8;
  localparam int unsigned DEF_CNT_W       = $clog2(DEF_BLOCK_BYTES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_LAST = 3'd2,
    ST_WR      = 3'd3,
    ST_RSP     = 3'd4
  } state_e;

  // Byte counter width for a block of n RAM words.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/aes_blk_shreg.sv
// Block-wide byte shift register: parallel load for writes, MSB-first shift for reads/writes.
module aes_blk_shreg #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load,
  input  logic                              shift,
  input  logic [DATA_WIDTH*BLOCK_BYTES-1:0] load_data,
  input  logic [DATA_WIDTH-1:0]             shift_in,
  output logic [DATA_WIDTH*BLOCK_BYTES-1:0] q
);

  localparam int unsigned BW = DATA_WIDTH * BLOCK_BYTES;

  // Load has priority; a shift moves every byte one slot towards the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[BW-DATA_WIDTH-1:0], shift_in};
    end
  end

endmodule

// File: rtl/aes_blk_mem_master.sv
// Moves one AES block between the core's load/store port and a byte-wide sync RAM.
module aes_blk_mem_master
  import aes_blk_mem_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [ADDR_WIDTH-1:0]             cmd_base,
  input  logic [DATA_WIDTH*BLOCK_BYTES-1:0] cmd_wblock,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [DATA_WIDTH*BLOCK_BYTES-1:0] rsp_rblock,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic                              mem_cs,
  output logic                              mem_we,
  output logic                              mem_oe,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int unsigned BW    = DATA_WIDTH * BLOCK_BYTES;
  localparam int unsigned CNT_W = cnt_width(BLOCK_BYTES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wr_q, wr_d;

  logic                  cmd_ready_d, rsp_valid_d, rsp_write_d;
  logic [BW-1:0]         rsp_rblock_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic                  mem_cs_d, mem_we_d, mem_oe_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;

  logic                  sh_load, sh_shift;
  logic [BW-1:0]         sh_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_byte;

  aes_blk_shreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_data(cmd_wblock),
    .shift_in (mem_rdata),
    .q        (sh_q)
  );

  // Address of the byte following the one currently on the bus; wraps modulo 2^ADDR_WIDTH.
  assign next_addr = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
  assign last_byte = (cnt_q == CNT_W'(BLOCK_BYTES - 1));

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      wr_q        <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rblock  <= '0;
      mem_address <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wr_q        <= wr_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_write   <= rsp_write_d;
      rsp_rblock  <= rsp_rblock_d;
      mem_address <= mem_address_d;
      mem_cs      <= mem_cs_d;
      mem_we      <= mem_we_d;
      mem_oe      <= mem_oe_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

  // Next state and next-cycle output values; RAM strobes idle unless a byte is issued.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    wr_d          = wr_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid;
    rsp_write_d   = rsp_write;
    rsp_rblock_d  = rsp_rblock;
    mem_address_d = '0;
    mem_cs_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_oe_d      = 1'b0;
    mem_wdata_d   = '0;
    sh_load       = 1'b0;
    sh_shift      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          base_d        = cmd_base;
          wr_d          = cmd_write;
          cnt_d         = '0;
          mem_cs_d      = 1'b1;
          mem_address_d = cmd_base;
          if (cmd_write) begin
            state_d     = ST_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = cmd_wblock[BW-1 -: DATA_WIDTH];
            sh_load     = 1'b1;
          end else begin
            state_d  = ST_RD;
            mem_oe_d = 1'b1;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      ST_RD: begin
        // Data on mem_rdata belongs to the address issued one cycle earlier.
        sh_shift = (cnt_q != '0);
        if (last_byte) begin
          state_d = ST_RD_LAST;
        end else begin
          cnt_d         = cnt_q + CNT_W'(1);
          mem_cs_d      = 1'b1;
          mem_oe_d      = 1'b1;
          mem_address_d = next_addr;
        end
      end

      ST_RD_LAST: begin
        state_d      = ST_RSP;
        rsp_valid_d  = 1'b1;
        rsp_write_d  = wr_q;
        rsp_rblock_d = {sh_q[BW-DATA_WIDTH-1:0], mem_rdata};
      end

      ST_WR: begin
        // After each shift the register's second byte is the next byte to write.
        sh_shift = 1'b1;
        if (last_byte) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_write_d = wr_q;
        end else begin
          cnt_d         = cnt_q + CNT_W'(1);
          mem_cs_d      = 1'b1;
          mem_we_d      = 1'b1;
          mem_address_d = next_addr;
          mem_wdata_d   = sh_q[BW-DATA_WIDTH-1 -: DATA_WIDTH];
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_write_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_blk_mem_master.sv
// Scoreboard bench for aes_blk_mem_master with a behavioural byte RAM.
module tb_aes_blk_mem_master;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned NB = 16;
  localparam int unsigned BW = DW * NB;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_base;
  logic [BW-1:0] cmd_wblock;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [BW-1:0] rsp_rblock;
  logic [AW-1:0] mem_address;
  logic          mem_cs;
  logic          mem_we;
  logic          mem_oe;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  typedef struct packed {
    logic          wr;
    logic [BW-1:0] blk;
  } exp_t;

  exp_t          sb[$];
  logic [7:0]    ram     [256];
  logic [7:0]    ref_mem [256];
  logic [7:0]    addr_log[$];
  int            acc_log[$];
  logic          ram_init;
  int            cyc;
  int            both_hi;
  int            wdata_bad;
  int            errors;
  int            checks;

  aes_blk_mem_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_base   (cmd_base),
    .cmd_wblock (cmd_wblock),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rblock (rsp_rblock),
    .mem_address(mem_address),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return (i < 16) ? 8'(i) : (8'(i) ^ 8'hA5);
  endfunction

  function automatic logic [BW-1:0] gather(input logic [7:0] base);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NB); i++) r[BW-1-8*i -: 8] = ref_mem[8'(base + 8'(i))];
    return r;
  endfunction

  // RAM model plus bus monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
    end else begin
      if (mem_cs && mem_we) ram[mem_address] <= mem_wdata;
      if (mem_cs && mem_oe) mem_rdata <= ram[mem_address];
    end
    if (mem_cs) addr_log.push_back(mem_address);
    if (rst_n && cmd_valid && cmd_ready) acc_log.push_back(cyc);
    if (mem_we && mem_oe) both_hi <= both_hi + 1;
    if (!mem_we && mem_wdata != '0) wdata_bad <= wdata_bad + 1;
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a command and wait for its accept; pushes the expected response.
  task automatic issue(input logic wr, input logic [7:0] base, input logic [BW-1:0] blk,
                       input bit hold, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_base   = base;
    cmd_wblock = blk;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", BW'(cmd_ready), BW'(1));
    acc   = cyc;
    e.wr  = wr;
    e.blk = wr ? '0 : gather(base);
    if (wr) for (int i = 0; i < int'(NB); i++) ref_mem[8'(base + 8'(i))] = blk[BW-1-8*i -: 8];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall, then hand shake.
  task automatic finish_rsp(input int acc, input int lat, input int stall, output int rsp_cyc);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", BW'(rsp_valid), BW'(1));
    rsp_cyc = cyc;
    check("latency", BW'(rsp_cyc - acc), BW'(lat));
    check("sb_nonempty", BW'(sb.size() != 0), BW'(1));
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    check("rsp_write", BW'(rsp_write), BW'(e.wr));
    if (!e.wr) check("rsp_rblock", rsp_rblock, e.blk);
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", BW'(rsp_valid), BW'(1));
      check("stall_cmd_ready", BW'(cmd_ready), BW'(0));
      check("stall_mem_cs", BW'(mem_cs), BW'(0));
      if (!e.wr) check("stall_rblock", rsp_rblock, e.blk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_cmd_ready", BW'(cmd_ready), BW'(1));
    check("idle_rsp_valid", BW'(rsp_valid), BW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, rc, acc2, rc2, diff;
    logic [BW-1:0] blk_a, blk_b;
    errors = 0; checks = 0; cyc = 0; both_hi = 0; wdata_bad = 0;
    blk_a = 128'h3243F6A8885A308D313198A2E0370734;
    blk_b = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    rst_n = 1'b0; ram_init = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_wblock = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    check("rst_cmd_ready", BW'(cmd_ready), BW'(1));
    check("rst_rsp_valid", BW'(rsp_valid), BW'(0));
    check("rst_mem_cs", BW'({mem_cs, mem_we, mem_oe}), BW'(0));
    check("rst_mem_addr", BW'(mem_address), BW'(0));
    check("rst_rblock", rsp_rblock, BW'(0));
    rst_n = 1'b1;

    // Plain read of the preloaded counting pattern.
    issue(1'b0, 8'h00, '0, 1'b0, acc);
    finish_rsp(acc, 18, 0, rc);
    check("read0_const", rsp_rblock, 128'h000102030405060708090A0B0C0D0E0F);

    // Write the FIPS-197 plaintext block, then inspect the RAM.
    issue(1'b1, 8'h20, blk_a, 1'b0, acc);
    finish_rsp(acc, 17, 0, rc);
    check("write_rblock_kept", rsp_rblock, 128'h000102030405060708090A0B0C0D0E0F);
    check("ram_20", BW'(ram[8'h20]), BW'(8'h32));
    check("ram_2f", BW'(ram[8'h2F]), BW'(8'h34));
    diff = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) diff++;
    check("ram_diff_count", BW'(diff), BW'(0));

    // Read back the written block.
    issue(1'b0, 8'h20, '0, 1'b0, acc);
    finish_rsp(acc, 18, 0, rc);
    check("readback_const", rsp_rblock, blk_a);

    // Wrapping read across the top of the address space.
    addr_log.delete();
    issue(1'b0, 8'hF8, '0, 1'b0, acc);
    finish_rsp(acc, 18, 0, rc);
    check("wrap_addr_count", BW'(addr_log.size()), BW'(NB));
    for (int i = 0; i < int'(NB) && i < addr_log.size(); i++)
      check($sformatf("wrap_addr_%0d", i), BW'(addr_log[i]), BW'(8'(8'hF8 + 8'(i))));

    // Response back-pressure.
    rsp_ready = 1'b0;
    issue(1'b0, 8'h20, '0, 1'b0, acc);
    finish_rsp(acc, 18, 5, rc);

    // Reset in cycle 8 of a read.
    issue(1'b0, 8'h00, '0, 1'b0, acc);
    while (cyc < acc + 8) @(negedge clk);
    check("pre_rst_cs", BW'(mem_cs), BW'(1));
    rst_n = 1'b0;
    #1;
    check("arst_cs_oe", BW'({mem_cs, mem_oe}), BW'(0));
    check("arst_rsp_valid", BW'(rsp_valid), BW'(0));
    check("arst_rblock", rsp_rblock, BW'(0));
    check("arst_cmd_ready", BW'(cmd_ready), BW'(1));
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 8'h18, '0, 1'b0, acc);
    finish_rsp(acc, 18, 0, rc);

    // cmd_valid held through a read, then a write to the same base queued behind it.
    acc_log.delete();
    issue(1'b0, 8'h20, '0, 1'b1, acc);
    cmd_write  = 1'b1;
    cmd_wblock = blk_b;
    begin
      exp_t e;
      e.wr = 1'b1; e.blk = '0;
      sb.push_back(e);
      for (int i = 0; i < int'(NB); i++) ref_mem[8'(8'h20 + 8'(i))] = blk_b[BW-1-8*i -: 8];
    end
    finish_rsp(acc, 18, 0, rc);
    acc2 = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    finish_rsp(acc2, 17, 0, rc2);
    check("b2b_accepts", BW'(acc_log.size()), BW'(2));
    if (acc_log.size() >= 2) begin
      check("b2b_first", BW'(acc_log[0]), BW'(acc));
      check("b2b_spacing", BW'(acc_log[1] - acc_log[0]), BW'(19));
      check("b2b_after_hs", BW'(acc_log[1]), BW'(rc + 1));
    end
    issue(1'b0, 8'h20, '0, 1'b0, acc);
    finish_rsp(acc, 18, 0, rc);
    check("b2b_readback", rsp_rblock, blk_b);

    check("we_oe_overlap", BW'(both_hi), BW'(0));
    check("wdata_idle_zero", BW'(wdata_bad), BW'(0));
    check("sb_drained", BW'(sb.size()), BW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
